// File: rtl/ops_pkg.sv
// ops_pkg: op-code constants and state enumeration shared by the ops_seq design and bench.
package ops_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MOD = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/ops_seq_if.sv
// ops_seq_if: command/response handshake bundle between an initiator and ops_seq.
interface ops_seq_if #(parameter int W = 8) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   cmd_op;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;
    modport master (output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
                    input  cmd_ready, rsp_valid, rsp_data, rsp_err);
    modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
                    output cmd_ready, rsp_valid, rsp_data, rsp_err);
endinterface

// File: rtl/ops_moddiv.sv
// ops_moddiv: restoring shift-subtract remainder, one iteration per cycle, W cycles from start.
module ops_moddiv #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] rem
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0]  r, q, d, nr;
    logic [W:0]    sh;
    logic [CW-1:0] cnt;
    logic          run;
    assign sh = {r, q[W-1]};
    // done flags the cycle whose edge performs the last iteration, so rem is the next remainder
    always_comb nr = (sh >= {1'b0, d}) ? W'(sh - {1'b0, d}) : sh[W-1:0];
    assign done = run && cnt == CW'(1);
    assign rem  = nr;
    always_ff @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
            r   <= '0;
            q   <= '0;
            d   <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= CW'(W);
            r   <= '0;
            q   <= a;
            d   <= b;
        end else if (run) begin
            run <= cnt != CW'(1);
            cnt <= cnt - CW'(1);
            r   <= nr;
            q   <= q << 1;
        end
    end
endmodule

// File: rtl/ops_seq.sv
// ops_seq: single-command arithmetic sequencer (ADD/MOD/AND/OR) with valid/ready handshakes.
module ops_seq
    import ops_pkg::*;
#(parameter int W = 8) (
    input  logic        clk,
    input  logic        rst,
    ops_seq_if.slave    bus,
    output logic        busy,
    output logic [15:0] done_cnt
);
    state_t       state;
    logic         accept, div_start, div_done;
    logic [W-1:0] alu, div_rem;
    assign bus.cmd_ready = state == IDLE;
    assign bus.rsp_valid = state == DONE;
    assign busy          = state != IDLE;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign div_start     = accept && bus.cmd_op == OP_MOD && bus.cmd_b != '0;
    always_comb alu = bus.cmd_op == OP_ADD ? bus.cmd_a + bus.cmd_b :
                      bus.cmd_op == OP_AND ? bus.cmd_a & bus.cmd_b :
                      bus.cmd_op == OP_OR  ? bus.cmd_a | bus.cmd_b : bus.cmd_a;
    ops_moddiv #(.W(W)) u_div (
        .clk(clk),
        .rst(rst),
        .start(div_start),
        .a(bus.cmd_a),
        .b(bus.cmd_b),
        .done(div_done),
        .rem(div_rem)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
            done_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    state <= div_start ? CALC : DONE;
                    if (!div_start) begin
                        bus.rsp_data <= alu;
                        bus.rsp_err  <= bus.cmd_op == OP_MOD;
                    end
                end
                CALC: if (div_done) begin
                    state        <= DONE;
                    bus.rsp_data <= div_rem;
                    bus.rsp_err  <= 1'b0;
                end
                DONE: if (bus.rsp_ready) begin
                    state    <= IDLE;
                    done_cnt <= done_cnt + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
